matrix_elem_sender: RTL and testbench

Formats one signed matrix element, matrix ID, or bare line break as ASCII text and streams the bytes to the UART transmitter. It is the transmit-side responder for the `sender_*` handshake driven by the matrix input, display and result modules. Those callers hand it one value plus formatting flags per request. The block handles decimal conversion, sign, separators and UART flow control, then pulses `sender_done` once the last byte has been accepted.

---
 rtl/matrix_elem_sender.sv | 118 +++++++++++
 tb/tb_matrix_elem_sender.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/matrix_elem_sender.sv
// matrix_elem_sender: formats a signed element, ID or line break as ASCII and streams it to the UART
module matrix_elem_sender #(
  parameter int          DATA_W   = 8,
  parameter logic [7:0]  CHAR_SEP = 8'h20,
  parameter logic [7:0]  CHAR_EOL = 8'h0A
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sender_data,
  input  logic              sender_start,
  input  logic              sender_is_last_col,
  input  logic              sender_newline_only,
  input  logic              sender_id,
  output logic              sender_ready,
  output logic              sender_done,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_ready
);
  localparam int MW = DATA_W + 1;
  typedef enum logic [2:0] {IDLE, CONV, LOAD, EMIT, HOLD, FINISH} state_t;
  state_t state;
  logic [MW-1:0] mag, mag_in;
  logic [3:0] hund, tens, len, p;
  logic [2:0] idx;
  logic neg_q, last_q, nl_q, id_q;
  logic [7:0] bytes_q [8];
  logic [7:0] nb [8];
  assign mag_in = sender_id ? {1'b0, sender_data}
                : sender_data[DATA_W-1] ? -{sender_data[DATA_W-1], sender_data}
                : {1'b0, sender_data};
  assign sender_ready = (state == IDLE) && !rst;
  assign tx_start = (state == EMIT) && tx_ready;
  assign tx_data = tx_start ? bytes_q[idx] : 8'h00;
  always_comb begin
    nb = '{default: 8'h00};
    p = 4'd0;
    if (nl_q) begin
      nb[0] = CHAR_EOL;
      p = 4'd1;
    end else begin
      if (id_q) begin
        nb[0] = 8'h49;
        nb[1] = 8'h44;
        nb[2] = 8'h3A;
        p = 4'd3;
      end else if (neg_q) begin
        nb[0] = 8'h2D;
        p = 4'd1;
      end
      if (hund != 4'd0) begin
        nb[p[2:0]] = 8'h30 + {4'h0, hund};
        p = p + 4'd1;
      end
      if (hund != 4'd0 || tens != 4'd0) begin
        nb[p[2:0]] = 8'h30 + {4'h0, tens};
        p = p + 4'd1;
      end
      nb[p[2:0]] = 8'h30 + {4'h0, mag[3:0]};
      p = p + 4'd1;
      nb[p[2:0]] = (last_q || id_q) ? CHAR_EOL : CHAR_SEP;
      p = p + 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mag         <= '0;
      hund        <= '0;
      tens        <= '0;
      len         <= '0;
      idx         <= '0;
      neg_q       <= 1'b0;
      last_q      <= 1'b0;
      nl_q        <= 1'b0;
      id_q        <= 1'b0;
      bytes_q     <= '{default: 8'h00};
      sender_done <= 1'b0;
    end else begin
      sender_done <= 1'b0;
      case (state)
        IDLE: if (sender_start) begin
          neg_q  <= sender_data[DATA_W-1] & ~sender_id;
          last_q <= sender_is_last_col;
          nl_q   <= sender_newline_only;
          id_q   <= sender_id;
          mag    <= mag_in;
          hund   <= '0;
          tens   <= '0;
          idx    <= '0;
          state  <= sender_newline_only ? LOAD : CONV;
        end
        CONV: if (mag >= MW'(100)) begin
          mag  <= mag - MW'(100);
          hund <= hund + 4'd1;
        end else if (mag >= MW'(10)) begin
          mag  <= mag - MW'(10);
          tens <= tens + 4'd1;
        end else state <= LOAD;
        LOAD: begin
          bytes_q <= nb;
          len     <= p;
          state   <= EMIT;
        end
        EMIT: if (tx_ready) state <= HOLD;
        HOLD: if ({1'b0, idx} + 4'd1 < len) begin
          idx   <= idx + 3'd1;
          state <= EMIT;
        end else begin
          sender_done <= 1'b1;
          state       <= FINISH;
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_elem_sender.sv
// tb_matrix_elem_sender: directed scoreboard bench for matrix_elem_sender
module tb_matrix_elem_sender;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] sender_data;
  logic sender_start, sender_is_last_col, sender_newline_only, sender_id;
  logic sender_ready, sender_done, tx_start, tx_ready;
  logic [7:0] tx_data;
  logic [7:0] q [$];
  logic [7:0] exp_b;
  int n_chk = 0, n_fail = 0, n_bytes = 0, done_cnt = 0, cyc = 0, last_strobe = 0, base = 0, t = 0;
  bit prev_strobe = 1'b0;
  matrix_elem_sender dut (
    .clk(clk), .rst(rst), .sender_data(sender_data), .sender_start(sender_start),
    .sender_is_last_col(sender_is_last_col), .sender_newline_only(sender_newline_only),
    .sender_id(sender_id), .sender_ready(sender_ready), .sender_done(sender_done),
    .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (tx_start) begin
      n_chk++;
      assert (tx_ready === 1'b1) else begin n_fail++; $error("FAIL strobe_busy: tx_ready=%b required 1", tx_ready); end
      n_chk++;
      assert (prev_strobe === 1'b0) else begin n_fail++; $error("FAIL back_to_back: prev strobe=%b required 0", prev_strobe); end
      n_chk++;
      assert (q.size() > 0) else begin n_fail++; $error("FAIL unexpected_byte: got %h with empty scoreboard", tx_data); end
      if (q.size() > 0) begin
        exp_b = q.pop_front();
        n_chk++;
        assert (tx_data === exp_b) else begin n_fail++; $error("FAIL tx_byte: got %h required %h", tx_data, exp_b); end
      end
      n_bytes++;
      last_strobe = cyc;
    end
    if (sender_done) begin
      done_cnt++;
      n_chk++;
      assert (cyc - last_strobe === 2) else begin n_fail++; $error("FAIL done_latency: got %0d required 2", cyc - last_strobe); end
    end
    prev_strobe = tx_start;
  end
  task automatic req(input logic [7:0] d, input logic last, input logic nl, input logic id);
    @(posedge clk); #1;
    sender_data = d; sender_is_last_col = last; sender_newline_only = nl; sender_id = id; sender_start = 1'b1;
    @(posedge clk); #1;
    sender_start = 1'b0; sender_data = ~d; sender_is_last_col = ~last; sender_newline_only = 1'b0; sender_id = ~id;
    @(negedge clk);
    n_chk++;
    assert (sender_ready === 1'b0) else begin n_fail++; $error("FAIL ready_after_accept: got %b required 0", sender_ready); end
  endtask
  task automatic wait_done(input int exp_cnt);
    int k = 0;
    do begin @(negedge clk); k++; end while (sender_done !== 1'b1 && k < 500);
    n_chk++;
    assert (sender_done === 1'b1) else begin n_fail++; $error("FAIL done_timeout: done=%b required 1", sender_done); end
    @(negedge clk);
    n_chk++;
    assert (sender_ready === 1'b1) else begin n_fail++; $error("FAIL ready_after_done: got %b required 1", sender_ready); end
    n_chk++;
    assert (done_cnt === exp_cnt) else begin n_fail++; $error("FAIL done_count: got %0d required %0d", done_cnt, exp_cnt); end
    n_chk++;
    assert (q.size() === 0) else begin n_fail++; $error("FAIL bytes_left: got %0d required 0", q.size()); end
  endtask
  task automatic push_model(input logic [7:0] d, input logic last, input logic nl, input logic id);
    string s;
    if (nl) q.push_back(8'h0A);
    else begin
      s = id ? $sformatf("ID:%0d", d) : $sformatf("%0d", $signed(d));
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      q.push_back((last || id) ? 8'h0A : 8'h20);
    end
  endtask
  initial begin
    rst = 1'b1; sender_data = '0; sender_start = 1'b0; sender_is_last_col = 1'b0;
    sender_newline_only = 1'b0; sender_id = 1'b0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; assert (sender_ready === 1'b0) else begin n_fail++; $error("FAIL rst_ready: got %b required 0", sender_ready); end
    n_chk++; assert (sender_done === 1'b0) else begin n_fail++; $error("FAIL rst_done: got %b required 0", sender_done); end
    n_chk++; assert (tx_start === 1'b0) else begin n_fail++; $error("FAIL rst_tx_start: got %b required 0", tx_start); end
    n_chk++; assert (tx_data === 8'h00) else begin n_fail++; $error("FAIL rst_tx_data: got %h required 00", tx_data); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_chk++; assert (sender_ready === 1'b1) else begin n_fail++; $error("FAIL ready_post_rst: got %b required 1", sender_ready); end
    q.push_back(8'h35); q.push_back(8'h20);
    req(8'd5, 1'b0, 1'b0, 1'b0); wait_done(1);
    q.push_back(8'h2D); q.push_back(8'h31); q.push_back(8'h32); q.push_back(8'h38); q.push_back(8'h0A);
    req(8'h80, 1'b1, 1'b0, 1'b0); wait_done(2);
    q.push_back(8'h30); q.push_back(8'h20);
    req(8'h00, 1'b0, 1'b0, 1'b0); wait_done(3);
    q.push_back(8'h0A);
    req(8'h7F, 1'b0, 1'b1, 1'b1); wait_done(4);
    q.push_back(8'h49); q.push_back(8'h44); q.push_back(8'h3A); q.push_back(8'h33); q.push_back(8'h0A);
    req(8'd3, 1'b0, 1'b0, 1'b1); wait_done(5);
    q.push_back(8'h31); q.push_back(8'h32); q.push_back(8'h37); q.push_back(8'h20);
    base = n_bytes;
    req(8'd127, 1'b0, 1'b0, 1'b0);
    t = 0;
    while (n_bytes < base + 2 && t < 100) begin @(negedge clk); t++; end
    n_chk++; assert (n_bytes === base + 2) else begin n_fail++; $error("FAIL second_byte: got %0d bytes required %0d", n_bytes - base, 2); end
    @(posedge clk); #1 tx_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      sender_start = (i % 10 == 3); sender_data = 8'h01;
    end
    sender_start = 1'b0;
    n_chk++; assert (n_bytes === base + 2) else begin n_fail++; $error("FAIL stall: got %0d bytes required %0d", n_bytes - base, 2); end
    tx_ready = 1'b1;
    wait_done(6);
    q.push_back(8'h2D); q.push_back(8'h34); q.push_back(8'h32); q.push_back(8'h20);
    base = n_bytes;
    req(8'hD6, 1'b0, 1'b0, 1'b0);
    t = 0;
    while (n_bytes < base + 1 && t < 100) begin @(negedge clk); t++; end
    n_chk++; assert (n_bytes === base + 1) else begin n_fail++; $error("FAIL first_byte: got %0d bytes required 1", n_bytes - base); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_chk++; assert (sender_ready === 1'b0) else begin n_fail++; $error("FAIL mid_rst_ready: got %b required 0", sender_ready); end
    n_chk++; assert (sender_done === 1'b0) else begin n_fail++; $error("FAIL mid_rst_done: got %b required 0", sender_done); end
    n_chk++; assert (tx_start === 1'b0) else begin n_fail++; $error("FAIL mid_rst_tx_start: got %b required 0", tx_start); end
    n_chk++; assert (tx_data === 8'h00) else begin n_fail++; $error("FAIL mid_rst_tx_data: got %h required 00", tx_data); end
    q.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    n_chk++; assert (done_cnt === 6) else begin n_fail++; $error("FAIL aborted_done: got %0d required 6", done_cnt); end
    n_chk++; assert (sender_ready === 1'b1) else begin n_fail++; $error("FAIL ready_after_abort: got %b required 1", sender_ready); end
    q.push_back(8'h39); q.push_back(8'h0A);
    req(8'd9, 1'b1, 1'b0, 1'b0); wait_done(7);
    begin
      logic [7:0] vals [8] = '{8'hFF, 8'd99, 8'd100, 8'd10, 8'hF7, 8'd255, 8'd200, 8'h81};
      logic ids [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) begin
        push_model(vals[i], i[0], 1'b0, ids[i]);
        req(vals[i], i[0], 1'b0, ids[i]);
        wait_done(8 + i);
      end
      for (int i = 0; i < 4; i++) begin
        vals[0] = 8'($urandom_range(0, 255));
        push_model(vals[0], i[0], 1'b0, 1'b0);
        req(vals[0], i[0], 1'b0, 1'b0);
        wait_done(16 + i);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
